// File: rtl/io_bridge_rr.sv
// Round-robin N-port Wishbone-to-I/O bridge with IO_BASE filtering, bus timeout and byte-lane steering.
// Optional posted writes: define IOBRIDGE_POSTED_WR_EN.
module io_bridge_rr #(
    parameter int          NPORTS  = 4,
    parameter int          DW      = 32,
    parameter logic [11:0] IO_BASE = 12'hFFD,
    parameter int          TIMEOUT = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NPORTS-1:0]          s_cyc_i,
    input  logic [NPORTS-1:0]          s_stb_i,
    input  logic [NPORTS-1:0]          s_we_i,
    input  logic [NPORTS*(DW/8)-1:0]   s_sel_i,
    input  logic [NPORTS*32-1:0]       s_adr_i,
    input  logic [NPORTS*DW-1:0]       s_dat_i,
    output logic [NPORTS-1:0]          s_ack_o,
    output logic [NPORTS-1:0]          s_err_o,
    output logic [DW-1:0]              s_dat_o,
    output logic                       m_cyc_o,
    output logic                       m_stb_o,
    output logic                       m_we_o,
    input  logic                       m_ack_i,
    output logic [DW/8-1:0]            m_sel_o,
    output logic [31:0]                m_adr_o,
    input  logic [DW-1:0]              m_dat_i,
    output logic [DW-1:0]              m_dat_o,
    output logic [7:0]                 m_dat8_o
);

    localparam int SW = DW / 8;
    localparam int LB = $clog2(SW);
    localparam int PW = $clog2(NPORTS);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_WAIT_NACK,
        ST_WR_ACK,
        ST_WR_ACK2
    } state_t;

    state_t            r_state;
    logic [PW-1:0]     r_rr;
    logic [PW-1:0]     r_gnt;
    logic [7:0]        r_cnt;
    logic              r_cyc;
    logic              r_stb;
    logic              r_we;
    logic [SW-1:0]     r_sel;
    logic [31:0]       r_adr;
    logic [DW-1:0]     r_dat;
    logic [7:0]        r_dat8;
    logic [NPORTS-1:0] r_ack;
    logic [NPORTS-1:0] r_err;
    logic [DW-1:0]     r_sdat;

    logic [NPORTS-1:0] w_req;
    logic              w_any;
    logic [PW-1:0]     w_gnt;
    logic [PW-1:0]     w_rr_next;
    logic              w_we;
    logic [SW-1:0]     w_sel;
    logic [19-LB:0]    w_adr_mid;
    logic [DW-1:0]     w_dat;
    logic [LB-1:0]     w_lane;
    logic [7:0]        w_dat8;

    always_comb begin
        w_req = '0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            w_req[p] = s_cyc_i[p] & s_stb_i[p] & (s_adr_i[p*32+20 +: 12] == IO_BASE);
        end
    end

    // Scan ports starting at the rr pointer, wrapping at NPORTS.
    always_comb begin
        logic [31:0] idx;
        idx   = '0;
        w_any = 1'b0;
        w_gnt = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            idx = 32'(r_rr) + i;
            if (idx >= NPORTS) idx = idx - NPORTS;
            if (!w_any && w_req[idx[PW-1:0]]) begin
                w_any = 1'b1;
                w_gnt = idx[PW-1:0];
            end
        end
    end

    assign w_rr_next = (w_gnt == PW'(NPORTS - 1)) ? '0 : w_gnt + 1'b1;
    assign w_we      = s_we_i[w_gnt];
    assign w_sel     = s_sel_i[w_gnt*SW +: SW];
    assign w_adr_mid = s_adr_i[w_gnt*32 + LB +: 20-LB];
    assign w_dat     = s_dat_i[w_gnt*DW +: DW];

    always_comb begin
        w_lane = '0;
        for (int unsigned i = 0; i < SW; i++) begin
            if (w_sel[SW-1-i]) w_lane = LB'(SW - 1 - i);
        end
    end

    assign w_dat8 = w_dat[w_lane*8 +: 8];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_rr    <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_dat8  <= '0;
            r_ack   <= '0;
            r_err   <= '0;
            r_sdat  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!m_ack_i && w_any) begin
                        r_gnt  <= w_gnt;
                        r_rr   <= w_rr_next;
                        r_cnt  <= '0;
                        r_cyc  <= 1'b1;
                        r_stb  <= 1'b1;
                        r_we   <= w_we;
                        r_sel  <= w_sel;
                        r_dat  <= w_dat;
                        r_adr  <= {IO_BASE, w_adr_mid, w_lane};
                        r_dat8 <= w_dat8;
`ifdef IOBRIDGE_POSTED_WR_EN
                        if (w_we) begin
                            r_ack[w_gnt] <= 1'b1;
                            r_state      <= ST_WR_ACK;
                        end else begin
                            r_state <= ST_WAIT_ACK;
                        end
`else
                        r_state <= ST_WAIT_ACK;
`endif
                    end else begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_we  <= 1'b0;
                    end
                end
                ST_WAIT_ACK: begin
                    if (m_ack_i) begin
                        r_sdat       <= m_dat_i;
                        r_ack[r_gnt] <= 1'b1;
                        r_state      <= ST_WAIT_NACK;
                    end else if (!s_cyc_i[r_gnt]) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (TIMEOUT != 0 && r_cnt == TO_LAST) begin
                        r_cyc        <= 1'b0;
                        r_stb        <= 1'b0;
                        r_we         <= 1'b0;
                        r_err[r_gnt] <= 1'b1;
                        r_state      <= ST_WAIT_NACK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_NACK: begin
                    if (!s_stb_i[r_gnt]) begin
                        r_ack   <= '0;
                        r_err   <= '0;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
`ifdef IOBRIDGE_POSTED_WR_EN
                // Slave ack follows its strobe; the master cycle finishes independently.
                ST_WR_ACK: begin
                    if (!s_stb_i[r_gnt]) r_ack <= '0;
                    if (m_ack_i || (TIMEOUT != 0 && r_cnt == TO_LAST)) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_we  <= 1'b0;
                        if (s_stb_i[r_gnt] && r_ack[r_gnt]) begin
                            r_state <= ST_WR_ACK2;
                        end else begin
                            r_ack   <= '0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WR_ACK2: begin
                    if (!s_stb_i[r_gnt]) begin
                        r_ack   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_ack_o  = r_ack;
    assign s_err_o  = r_err;
    assign s_dat_o  = r_sdat;
    assign m_cyc_o  = r_cyc;
    assign m_stb_o  = r_stb;
    assign m_we_o   = r_we;
    assign m_sel_o  = r_sel;
    assign m_adr_o  = r_adr;
    assign m_dat_o  = r_dat;
    assign m_dat8_o = r_dat8;

endmodule

// File: tb/tb_io_bridge_rr.sv
// Self-checking bench for io_bridge_rr: vector table, directed multi-cycle sequences,
// and randomized traffic checked against a transaction-level round-robin model.
module tb_io_bridge_rr;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [3:0]   p_cyc, p_stb, p_we;
    logic [3:0]   p_sel [4];
    logic [31:0]  p_adr [4];
    logic [31:0]  p_dat [4];
    logic [15:0]  s_sel;
    logic [127:0] s_adr, s_dat;
    logic [3:0]   s_ack_o, s_err_o;
    logic [31:0]  s_dat_o;
    logic         m_cyc_o, m_stb_o, m_we_o, m_ack_i;
    logic [3:0]   m_sel_o;
    logic [31:0]  m_adr_o, m_dat_i, m_dat_o;
    logic [7:0]   m_dat8_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        s_sel = '0;
        s_adr = '0;
        s_dat = '0;
        for (int p = 0; p < 4; p++) begin
            s_sel[p*4 +: 4]   = p_sel[p];
            s_adr[p*32 +: 32] = p_adr[p];
            s_dat[p*32 +: 32] = p_dat[p];
        end
    end

    io_bridge_rr #(.NPORTS(4), .DW(32), .IO_BASE(12'hFFD), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .s_cyc_i(p_cyc), .s_stb_i(p_stb), .s_we_i(p_we),
        .s_sel_i(s_sel), .s_adr_i(s_adr), .s_dat_i(s_dat),
        .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_dat_o(s_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_ack_i(m_ack_i), .m_sel_o(m_sel_o), .m_adr_o(m_adr_o),
        .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_dat8_o(m_dat8_o)
    );

    typedef struct {
        int          port;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] ackdat;
        logic        go;
        logic [31:0] exp_adr;
        logic [7:0]  exp_dat8;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] dat);
        p_cyc[p] = 1'b1; p_stb[p] = 1'b1; p_we[p] = we;
        p_sel[p] = sel;  p_adr[p] = adr;  p_dat[p] = dat;
    endtask

    task automatic drop(input int p);
        p_cyc[p] = 1'b0;
        p_stb[p] = 1'b0;
    endtask

    function automatic int exp_lane(input logic [3:0] s);
        int r = 0;
        for (int i = 3; i >= 0; i--) if (s[i]) r = i;
        return r;
    endfunction

    function automatic logic [31:0] exp_adr(input logic [31:0] a, input int lane);
        return 32'hFFD0_0000 | (a & 32'h000F_FFFC) | 32'(lane);
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"}, s_ack_o, 0);
        chk({tag, "_err"}, s_err_o, 0);
        chk({tag, "_sdat"}, s_dat_o, 0);
        chk({tag, "_mctl"}, {m_cyc_o, m_stb_o, m_we_o}, 0);
        chk({tag, "_msel"}, m_sel_o, 0);
        chk({tag, "_madr"}, m_adr_o, 0);
        chk({tag, "_mdat"}, {m_dat_o, m_dat8_o}, 0);
    endtask

    // Waits for the master strobe, checks the steered request, acks it and releases the port.
    task automatic serve(input int p, input int dly, input bit rearm);
        int w;
        int lane;
        logic [31:0] d;
        w = 0;
        while (!m_stb_o && w < 20) begin
            tick();
            w++;
        end
        if (!m_stb_o) begin
            chk("stb_wait", 0, 1);
            drop(p);
            tick();
            return;
        end
        lane = exp_lane(p_sel[p]);
        chk("m_adr", m_adr_o, exp_adr(p_adr[p], lane));
        chk("m_sel", m_sel_o, p_sel[p]);
        chk("m_we", m_we_o, p_we[p]);
        chk("m_dat_o", m_dat_o, p_dat[p]);
        chk("m_dat8", m_dat8_o, (p_dat[p] >> (8 * lane)) & 32'hFF);
        repeat (dly) tick();
        d = $urandom;
        m_ack_i = 1'b1;
        m_dat_i = d;
        tick();
        m_ack_i = 1'b0;
        chk("s_ack", s_ack_o, 64'(1) << p);
        chk("s_dat", s_dat_o, d);
        chk("s_err", s_err_o, 0);
        p_stb[p] = 1'b0;
        if (!rearm) p_cyc[p] = 1'b0;
        tick();
        chk("ack_clr", s_ack_o, 0);
        chk("m_cyc_end", m_cyc_o, 0);
        if (rearm) p_stb[p] = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   ptr;
        int   ex;
        bit   bad;
        logic active [4];
        logic valid  [4];
        logic [11:0] top;

        tbl[0] = '{0, 1'b0, 4'hF, 32'hFFD0_0004, 32'h0000_0000, 32'h1234_5678, 1'b1, 32'hFFD0_0004, 8'h00};
        tbl[1] = '{2, 1'b1, 4'h4, 32'hFFD0_0010, 32'hAABB_CCDD, 32'h0000_0001, 1'b1, 32'hFFD0_0012, 8'hBB};
        tbl[2] = '{3, 1'b0, 4'hF, 32'hFFC0_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0,         8'h00};
        tbl[3] = '{1, 1'b1, 4'h8, 32'hFFDA_BCD8, 32'h1122_3344, 32'h5555_AAAA, 1'b1, 32'hFFDA_BCDB, 8'h11};
        tbl[4] = '{0, 1'b0, 4'h0, 32'hFFD0_0013, 32'h5566_7788, 32'h0BAD_F00D, 1'b1, 32'hFFD0_0010, 8'h88};
        tbl[5] = '{3, 1'b0, 4'h1, 32'h7FD0_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0,         8'h00};
        tbl[6] = '{1, 1'b0, 4'hA, 32'hFFD0_0020, 32'hCAFE_BABE, 32'h8765_4321, 1'b1, 32'hFFD0_0021, 8'hBA};

        p_cyc = '0; p_stb = '0; p_we = '0;
        for (int p = 0; p < 4; p++) begin
            p_sel[p] = '0; p_adr[p] = '0; p_dat[p] = '0;
        end
        m_ack_i = 1'b0;
        m_dat_i = '0;
        rst_i   = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst_i = 1'b0;

        // Round-robin from reset: ports 1 and 3 both keep requesting.
        set_req(1, 1'b0, 4'hF, 32'hFFD0_1000, 32'h0);
        set_req(3, 1'b0, 4'hF, 32'hFFD0_3000, 32'h0);
        tick();
        chk("rr_stb_lat", m_stb_o, 1);
        serve(1, 0, 1'b1);
        serve(3, 1, 1'b1);
        serve(1, 0, 1'b0);
        serve(3, 2, 1'b0);

        for (int i = 0; i < 7; i++) begin
            set_req(tbl[i].port, tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].dat);
            tick();
            if (tbl[i].go) begin
                chk("tbl_stb", m_stb_o, 1);
                chk("tbl_adr", m_adr_o, tbl[i].exp_adr);
                chk("tbl_dat8", m_dat8_o, tbl[i].exp_dat8);
                chk("tbl_sel", m_sel_o, tbl[i].sel);
                chk("tbl_we", m_we_o, tbl[i].we);
                m_ack_i = 1'b1;
                m_dat_i = tbl[i].ackdat;
                tick();
                m_ack_i = 1'b0;
                chk("tbl_ack", s_ack_o, 64'(1) << tbl[i].port);
                chk("tbl_sdat", s_dat_o, tbl[i].ackdat);
                drop(tbl[i].port);
                tick();
                chk("tbl_ack_clr", s_ack_o, 0);
            end else begin
                bad = 1'b0;
                repeat (10) begin
                    if (m_cyc_o || s_ack_o != 0 || s_err_o != 0) bad = 1'b1;
                    tick();
                end
                chk("tbl_nogo", bad, 0);
                drop(tbl[i].port);
                tick();
            end
        end

        // Timeout: no master ack, error exactly eight cycles after the strobe rises.
        set_req(0, 1'b0, 4'hF, 32'hFFD0_0100, 32'h0);
        tick();
        chk("to_stb", m_stb_o, 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("to_cyc", m_cyc_o, (k < 8) ? 1 : 0);
            chk("to_err", s_err_o, (k == 8) ? 1 : 0);
        end
        chk("to_noack", s_ack_o, 0);
        drop(0);
        tick();
        chk("to_err_clr", s_err_o, 0);

        // Abort: granted cyc drops while waiting for the device.
        set_req(2, 1'b0, 4'hF, 32'hFFD0_0200, 32'h0);
        tick();
        chk("ab_stb", m_stb_o, 1);
        tick();
        tick();
        drop(2);
        tick();
        chk("ab_cyc", m_cyc_o, 0);
        bad = 1'b0;
        repeat (5) begin
            if (s_ack_o != 0 || s_err_o != 0 || m_cyc_o) bad = 1'b1;
            tick();
        end
        chk("ab_quiet", bad, 0);

        // Reset in the middle of a completed-but-held transfer.
        set_req(1, 1'b0, 4'hF, 32'hFFD0_0300, 32'h0);
        tick();
        m_ack_i = 1'b1;
        m_dat_i = 32'hDEAD_BEEF;
        tick();
        m_ack_i = 1'b0;
        chk("rm_ack", s_ack_o, 4'b0010);
        rst_i = 1'b1;
        tick();
        check_all_zero("midrst");
        drop(1);
        tick();
        rst_i = 1'b0;

        ptr = 0;
        for (int p = 0; p < 4; p++) begin
            active[p] = 1'b0;
            valid[p]  = 1'b0;
        end
        for (int it = 0; it < 80; it++) begin
            for (int p = 0; p < 4; p++) begin
                if (!active[p] && $urandom_range(0, 1) == 1) begin
                    valid[p] = ($urandom_range(0, 3) != 0);
                    top = valid[p] ? 12'hFFD : 12'($urandom);
                    if (!valid[p] && top == 12'hFFD) top = top ^ 12'h001;
                    set_req(p, 1'($urandom), 4'($urandom), {top, 20'($urandom)}, $urandom);
                    active[p] = 1'b1;
                end else if (active[p] && !valid[p] && $urandom_range(0, 2) == 0) begin
                    drop(p);
                    active[p] = 1'b0;
                end
            end
            ex = -1;
            for (int i = 0; i < 4; i++) begin
                int q;
                q = (ptr + i) % 4;
                if (ex < 0 && active[q] && valid[q]) ex = q;
            end
            if (ex < 0) begin
                bad = 1'b0;
                repeat (3) begin
                    tick();
                    if (m_cyc_o || s_ack_o != 0 || s_err_o != 0) bad = 1'b1;
                end
                chk("rnd_idle", bad, 0);
            end else begin
                serve(ex, $urandom_range(0, 3), 1'b0);
                active[ex] = 1'b0;
                ptr = (ex + 1) % 4;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
